// File: rtl/step_limiter_pkg.sv
// Shared definitions for the step window limiter.
//   MODE_BITS            : width of the mode select
//   MODE_FREE/LIMIT/POST : mode select encodings (3 is reserved and behaves as FREE)
//   state_e              : limiter FSM state encoding
//   norm_mode()          : folds the reserved mode onto FREE
package step_limiter_pkg;

  localparam int MODE_BITS = 2;

  localparam logic [MODE_BITS-1:0] MODE_FREE  = 2'd0;
  localparam logic [MODE_BITS-1:0] MODE_LIMIT = 2'd1;
  localparam logic [MODE_BITS-1:0] MODE_POST  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_TRIG = 2'd1,
    ST_COUNT     = 2'd2,
    ST_STOPPED   = 2'd3
  } state_e;

  function automatic logic [MODE_BITS-1:0] norm_mode(input logic [MODE_BITS-1:0] m);
    return (m == 2'd3) ? MODE_FREE : m;
  endfunction

endpackage

// File: rtl/lim_edge_det.sv
// Level register with rise/fall pulse outputs.
//   clk    : clock
//   rst    : asynchronous active-high reset (registered level clears to 0)
//   d      : level input
//   q      : d delayed by one clock
//   rise   : d & ~q (first cycle the level is high)
//   fall   : ~d & q (first cycle the level is low)
module lim_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= 1'b0;
    else     q <= d;
  end

  assign rise = d & ~q;
  assign fall = ~d & q;

endmodule

// File: rtl/step_window_limiter.sv
// Step window limiter: counts capture step strobes during a run and raises
// o_stop once the programmed number of steps has been seen.
//   i_clk, i_rst  : clock, asynchronous active-high reset
//   i_run         : run level (low aborts to IDLE and clears everything)
//   i_step        : one-cycle step strobe
//   i_trigger     : starts counting in POST mode
//   i_rearm       : restarts counting from STOPPED
//   i_mode        : FREE / LIMIT / POST (3 behaves as FREE), latched at run start
//   i_limit       : step limit N, latched at run start
//   o_stop        : limit reached, capture must halt
//   o_done        : one-cycle pulse on the cycle o_stop rises
//   o_triggered   : counting has started in this session
//   o_count       : steps counted in the current window
//   o_ovf         : sticky FREE-mode saturation flag
module step_window_limiter
  import step_limiter_pkg::*;
#(
  parameter int COUNT_W = 32,
  parameter int MODE_W  = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_run,
  input  logic               i_step,
  input  logic               i_trigger,
  input  logic               i_rearm,
  input  logic [MODE_W-1:0]  i_mode,
  input  logic [COUNT_W-1:0] i_limit,
  output logic               o_stop,
  output logic               o_done,
  output logic               o_triggered,
  output logic [COUNT_W-1:0] o_count,
  output logic               o_ovf
);

  state_e               state_q, state_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic [COUNT_W-1:0]   limit_q, limit_d;
  logic [MODE_BITS-1:0] mode_q, mode_d;
  logic                 stop_q, stop_d;
  logic                 done_q, done_d;
  logic                 trig_q, trig_d;
  logic                 ovf_q, ovf_d;

  logic run_q, run_start, unused_run_fall;

  lim_edge_det u_run_edge (
    .clk  (i_clk),
    .rst  (i_rst),
    .d    (i_run),
    .q    (run_q),
    .rise (run_start),
    .fall (unused_run_fall)
  );

  logic [COUNT_W-1:0] count_inc;
  logic               limit_hit;

  // Full-width compare: a limit of all-ones is reached without wrapping.
  assign count_inc = count_q + 1'b1;
  assign limit_hit = (count_inc == limit_q);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    limit_d = limit_q;
    mode_d  = mode_q;
    stop_d  = stop_q;
    done_d  = 1'b0;
    trig_d  = trig_q;
    ovf_d   = ovf_q;

    if (!i_run) begin
      // Abort has top priority and drops any step in flight.
      state_d = ST_IDLE;
      count_d = '0;
      stop_d  = 1'b0;
      trig_d  = 1'b0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (run_start) begin
            limit_d = i_limit;
            mode_d  = norm_mode(i_mode);
            if (norm_mode(i_mode) == MODE_LIMIT && i_limit == '0) begin
              state_d = ST_STOPPED;
              stop_d  = 1'b1;
              done_d  = 1'b1;
            end else if (norm_mode(i_mode) == MODE_POST) begin
              state_d = ST_WAIT_TRIG;
            end else begin
              state_d = ST_COUNT;
              trig_d  = 1'b1;
            end
          end
        end
        ST_WAIT_TRIG: begin
          if (i_trigger) begin
            trig_d = 1'b1;
            if (limit_q == '0) begin
              state_d = ST_STOPPED;
              stop_d  = 1'b1;
              done_d  = 1'b1;
            end else begin
              state_d = ST_COUNT;
              // count_q is zero here, so a same-cycle step lands as 1.
              if (i_step) begin
                count_d = count_inc;
                if (limit_hit) begin
                  state_d = ST_STOPPED;
                  stop_d  = 1'b1;
                  done_d  = 1'b1;
                end
              end
            end
          end
        end
        ST_COUNT: begin
          if (i_step) begin
            if (mode_q == MODE_FREE) begin
              if (&count_q) ovf_d = 1'b1;
              else          count_d = count_inc;
            end else begin
              count_d = count_inc;
              if (limit_hit) begin
                state_d = ST_STOPPED;
                stop_d  = 1'b1;
                done_d  = 1'b1;
              end
            end
          end
        end
        ST_STOPPED: begin
          if (i_rearm) begin
            count_d = '0;
            stop_d  = 1'b0;
            if (mode_q == MODE_POST) begin
              state_d = ST_WAIT_TRIG;
              trig_d  = 1'b0;
            end else begin
              state_d = ST_COUNT;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      limit_q <= '0;
      mode_q  <= MODE_FREE;
      stop_q  <= 1'b0;
      done_q  <= 1'b0;
      trig_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      limit_q <= limit_d;
      mode_q  <= mode_d;
      stop_q  <= stop_d;
      done_q  <= done_d;
      trig_q  <= trig_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_stop      = stop_q;
  assign o_done      = done_q;
  assign o_triggered = trig_q;
  assign o_count     = count_q;
  assign o_ovf       = ovf_q;

endmodule

// File: tb/tb_step_window_limiter.sv
module tb_step_window_limiter;

  localparam int W    = 4;
  localparam int MAXV = (1 << W) - 1;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_run = 1'b0;
  logic         i_step = 1'b0;
  logic         i_trigger = 1'b0;
  logic         i_rearm = 1'b0;
  logic [1:0]   i_mode = 2'd0;
  logic [W-1:0] i_limit = '0;
  logic         o_stop, o_done, o_triggered, o_ovf;
  logic [W-1:0] o_count;

  step_window_limiter #(.COUNT_W(W), .MODE_W(2)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_run       (i_run),
    .i_step      (i_step),
    .i_trigger   (i_trigger),
    .i_rearm     (i_rearm),
    .i_mode      (i_mode),
    .i_limit     (i_limit),
    .o_stop      (o_stop),
    .o_done      (o_done),
    .o_triggered (o_triggered),
    .o_count     (o_count),
    .o_ovf       (o_ovf)
  );

  always #5 i_clk = ~i_clk;

  int    n_vec = 0;
  int    n_err = 0;
  string phase = "reset";

  // Reference model: session described by plain flags and integer counts.
  bit m_prev_run = 0;
  bit m_idle = 1, m_waiting = 0, m_counting = 0, m_halted = 0;
  int m_mode = 0, m_lim = 0;
  int e_count = 0;
  bit e_stop = 0, e_done = 0, e_trig = 0, e_ovf = 0;

  task automatic model_reset();
    m_prev_run = 0;
    m_idle = 1; m_waiting = 0; m_counting = 0; m_halted = 0;
    e_count = 0; e_stop = 0; e_done = 0; e_trig = 0; e_ovf = 0;
  endtask

  task automatic halt();
    m_halted = 1; m_counting = 0; m_waiting = 0;
    e_stop = 1; e_done = 1;
  endtask

  task automatic take_step();
    if (m_mode == 0) begin
      if (e_count == MAXV) e_ovf = 1;
      else e_count = e_count + 1;
    end else begin
      e_count = (e_count + 1) % (MAXV + 1);
      if (e_count == m_lim) halt();
    end
  endtask

  task automatic model_step(input bit run, input bit step, input bit trig, input bit rearm);
    bit start;
    start = run && !m_prev_run;
    m_prev_run = run;
    e_done = 0;
    if (!run) begin
      m_idle = 1; m_waiting = 0; m_counting = 0; m_halted = 0;
      e_count = 0; e_stop = 0; e_trig = 0; e_ovf = 0;
    end else if (m_idle) begin
      if (start) begin
        m_mode = (int'(i_mode) == 3) ? 0 : int'(i_mode);
        m_lim  = int'(i_limit);
        m_idle = 0;
        if (m_mode == 1 && m_lim == 0) halt();
        else if (m_mode == 2) m_waiting = 1;
        else begin m_counting = 1; e_trig = 1; end
      end
    end else if (m_waiting) begin
      if (trig) begin
        e_trig = 1;
        m_waiting = 0;
        if (m_lim == 0) halt();
        else begin
          m_counting = 1;
          if (step) take_step();
        end
      end
    end else if (m_counting) begin
      if (step) take_step();
    end else if (m_halted) begin
      if (rearm) begin
        e_count = 0; e_stop = 0; m_halted = 0;
        if (m_mode == 2) begin m_waiting = 1; e_trig = 0; end
        else m_counting = 1;
      end
    end
  endtask

  task automatic check(input string tag);
    n_vec++;
    assert (o_stop === e_stop) else begin
      n_err++; $error("FAIL %s stop: got %0b expected %0b", tag, o_stop, e_stop);
    end
    n_vec++;
    assert (o_done === e_done) else begin
      n_err++; $error("FAIL %s done: got %0b expected %0b", tag, o_done, e_done);
    end
    n_vec++;
    assert (o_triggered === e_trig) else begin
      n_err++; $error("FAIL %s triggered: got %0b expected %0b", tag, o_triggered, e_trig);
    end
    n_vec++;
    assert (o_count === 4'(e_count)) else begin
      n_err++; $error("FAIL %s count: got %0d expected %0d", tag, o_count, e_count);
    end
    n_vec++;
    assert (o_ovf === e_ovf) else begin
      n_err++; $error("FAIL %s ovf: got %0b expected %0b", tag, o_ovf, e_ovf);
    end
  endtask

  // One clock: drive, let the edge happen, advance the model, compare.
  task automatic cyc(input bit run, input bit step, input bit trig, input bit rearm);
    i_run = run; i_step = step; i_trigger = trig; i_rearm = rearm;
    @(posedge i_clk);
    if (!i_rst) model_step(run, step, trig, rearm);
    #1;
    check(phase);
    $display("[%0t] %s run=%0b step=%0b trig=%0b rearm=%0b -> stop=%0b done=%0b trig=%0b count=%0d ovf=%0b",
             $time, phase, run, step, trig, rearm, o_stop, o_done, o_triggered, o_count, o_ovf);
  endtask

  initial begin
    // Power-on reset
    phase = "reset";
    repeat (2) @(posedge i_clk);
    #1;
    check(phase);
    i_rst = 1'b0;
    cyc(0, 1, 0, 0);

    // LIMIT N=3, steps on cycles 2,4,6,7 after run start
    phase = "limit3";
    i_mode = 2'd1; i_limit = 4'd3;
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);

    // POST N=2: steps before trigger ignored, trigger+step counts
    phase = "post2";
    i_mode = 2'd2; i_limit = 4'd2;
    cyc(1, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1, 0, 0);
      cyc(1, 0, 0, 0);
    end
    cyc(1, 1, 1, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);

    // LIMIT N=0: stops at run start, steps ignored
    phase = "limit0";
    i_mode = 2'd1; i_limit = 4'd0;
    cyc(1, 1, 0, 0);
    for (int i = 0; i < 10; i++) cyc(1, 1, 0, 0);
    cyc(0, 0, 0, 0);

    // Rearm with coincident step, stop again, abort with a step in flight
    phase = "rearm";
    i_mode = 2'd1; i_limit = 4'd2;
    cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 1);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);

    // FREE: 17 steps saturate at 15, ovf on the 16th, no stop
    phase = "free_sat";
    i_mode = 2'd0; i_limit = 4'd3;
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 17; i++) cyc(1, 1, 0, 0);
    cyc(0, 0, 0, 0);

    // Reserved mode behaves as FREE
    phase = "mode3";
    i_mode = 2'd3; i_limit = 4'd1;
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0);
    cyc(0, 0, 0, 0);

    // Maximum limit reachable without wrap
    phase = "limit15";
    i_mode = 2'd1; i_limit = 4'd15;
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 16; i++) cyc(1, 1, 0, 0);
    cyc(0, 0, 0, 0);

    // Asynchronous reset mid-count
    phase = "async_rst";
    i_mode = 2'd1; i_limit = 4'd5;
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0);
    #2;
    i_rst = 1'b1;
    model_reset();
    #1;
    check(phase);
    i_run = 1'b0;
    @(posedge i_clk);
    #1;
    check(phase);
    i_rst = 1'b0;
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(0, 0, 0, 0);

    // Randomized sessions against the model
    phase = "random";
    for (int s = 0; s < 40; s++) begin
      i_mode  = 2'($urandom_range(0, 3));
      i_limit = 4'($urandom_range(0, MAXV));
      for (int c = 0; c < 25; c++) begin
        cyc(($urandom_range(0, 39) != 0) || c == 0 ? 1'b1 : 1'b0,
            1'($urandom_range(0, 1)),
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 7) == 0);
        if ($urandom_range(0, 5) == 0) begin
          i_mode  = 2'($urandom_range(0, 3));
          i_limit = 4'($urandom_range(0, MAXV));
        end
      end
      cyc(0, 0, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/step_window_limiter.md
Name: step_window_limiter

Overview:
Parametrised, fully synchronous successor to the analyzer's step limiter. It counts capture step strobes while a run is active and stops the capture after a programmed number of steps. Three modes are supported: free-running, fixed limit, and post-trigger limit, where counting starts only at a trigger. The block sits between the run/step sequencer and the sample-memory write enable; o_stop gates further captures.

Parameters:
COUNT_W, 32, width of the step counter and of the limit input
MODE_W, 2, width of the mode select (fixed; exposed for the package)

Ports:
i_clk  in  1  system clock; all logic on rising edge
i_rst  in  1  asynchronous, active-high reset
i_run  in  1  run level; high = capture session active
i_step  in  1  one-cycle step strobe, synchronous to i_clk
i_trigger  in  1  trigger qualifier level/pulse, used in POST mode
i_rearm  in  1  one-cycle pulse; restarts counting from STOPPED
i_mode  in  2  0=FREE, 1=LIMIT, 2=POST, 3=reserved (treated as FREE)
i_limit  in  COUNT_W  step limit N
o_stop  out  1  high = limit reached, capture must halt
o_done  out  1  one-cycle pulse on the cycle o_stop rises
o_triggered  out  1  high once counting has started in the session
o_count  out  COUNT_W  steps counted in current window
o_ovf  out  1  sticky: FREE-mode counter saturated

Behaviour:
- Reset (async, i_rst=1): state IDLE; o_stop=0, o_done=0, o_triggered=0, o_count=0, o_ovf=0, run_q=0, limit_q=0, mode_q=FREE.
- run_q is i_run registered. Run start = i_run & ~run_q.
- States: IDLE, WAIT_TRIG, COUNT, STOPPED.
- Priority each cycle: i_run=0 > i_rearm > i_trigger/i_step.
- i_run=0 in any state -> IDLE next edge. o_count, o_stop, o_triggered, o_ovf clear; in-flight steps dropped. This is the mid-operation abort.
- IDLE + run start: latch limit_q<=i_limit, mode_q<=i_mode. Mode and limit are ignored afterwards until the next run start.
  - LIMIT with i_limit==0 -> STOPPED; o_stop=1 and o_done pulses on that edge; no steps accepted.
  - POST (any limit) -> WAIT_TRIG.
  - FREE or LIMIT with N>0 -> COUNT, o_triggered<=1.
  - An i_step in the run-start cycle is not counted.
- WAIT_TRIG: steps ignored. When i_trigger=1 -> COUNT, o_triggered<=1. A step in the trigger cycle is counted, so o_count=1 at the next edge. POST with limit_q==0 -> STOPPED at trigger, with the same-cycle step not counted.
- COUNT: on i_step, o_count<=o_count+1.
  - LIMIT/POST: if o_count+1==limit_q, go to STOPPED on the same edge. o_stop<=1 and o_done<=1 for one cycle; o_count holds N.
  - Latency from the Nth step strobe to o_stop high is 1 clock.
  - Comparison is full COUNT_W, so limit_q=2^COUNT_W-1 is reachable with no wrap.
  - FREE: counter saturates at all-ones; o_ovf<=1 on the step that would wrap; o_stop never asserts.
- STOPPED: steps and trigger ignored; o_stop held high.
  - i_rearm -> o_count<=0, o_stop<=0, next state COUNT for LIMIT, or WAIT_TRIG with o_triggered<=0 for POST.
  - A step coincident with i_rearm is not counted.
  - i_rearm outside STOPPED is ignored.
- o_done is high only on the single cycle following the stop transition and is never high in IDLE.

Decomposition:
- Package step_limiter_pkg: mode constants MODE_FREE/LIMIT/POST (MODE_W bits) and the state enum (2 bits) with encodings.
- One natural sub-module: lim_edge_det. It registers a level and emits rise and fall pulses, and is reused for the run-start detection.
- The counter, compare and FSM stay in the top module.

Test Plan:
- Reset mid-count:
  - Stimulus: LIMIT N=5, 3 steps counted, then assert i_rst asynchronously.
  - Response: all outputs 0 immediately.
  - Follow-up: after release, a new run start is required before counting.
- LIMIT N=3 with steps on cycles 2, 4, 6, 7 after run start -> o_count 1, 2, 3; o_stop and o_done rise 1 clk after the cycle-6 step; the cycle-7 step is ignored, o_count stays 3; o_done lasts 1 cycle.
- POST N=2:
  - Stimulus: 4 steps before the trigger, then i_trigger and i_step in the same cycle, then one more step.
  - Response: o_count=0 until the trigger; then 1, then 2 with o_stop=1.
- LIMIT N=0 -> o_stop=1 and o_done pulse the cycle after run start; 10 steps leave o_count=0.
- Rearm and abort sequence, with N=2 starting in STOPPED:
  - i_rearm together with i_step -> o_stop=0, o_count=0 (step not counted).
  - Two steps -> stop again.
  - Drop i_run with i_step=1 -> IDLE, all cleared.
- FREE with COUNT_W=4: 17 steps -> o_count saturates at 15; o_ovf rises on the 16th step; o_stop stays 0.
